// File: rtl/trig_seq_gen_pkg.sv
// Shared types and default widths for the multi-channel trigger sequencer.
package trig_seq_gen_pkg;

  localparam int DEF_N_CH  = 17;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_DLY_W = 16;
  localparam int DEF_PW_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_st_e;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_DLY   = 2'd1,
    CH_PULSE = 2'd2
  } ch_st_e;

endpackage

// File: rtl/trig_seq_gen_ch_dly.sv
// One trigger channel: programmable delay after a master tick, then a
// fixed-width pulse. A new tick restarts the channel from its delay.
module trig_ch_dly
  import trig_seq_gen_pkg::*;
#(
  parameter int DLY_W = DEF_DLY_W,
  parameter int PW_W  = DEF_PW_W
) (
  input  logic             I_clk,
  input  logic             I_Rst,
  input  logic             I_clr,
  input  logic             I_tick,
  input  logic             I_en,
  input  logic [DLY_W-1:0] I_dly,
  input  logic [PW_W-1:0]  I_pw,
  output logic             O_trig,
  output logic             O_active
);

  localparam int CW = (DLY_W > PW_W) ? DLY_W : PW_W;
  localparam logic [CW-1:0] C_ONE = CW'(1);

  ch_st_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trig_q, trig_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (I_clr) begin
      st_d  = CH_IDLE;
      cnt_d = '0;
    end else if (I_tick && I_en) begin
      if (I_dly == '0) begin
        st_d  = CH_PULSE;
        cnt_d = CW'(I_pw) - C_ONE;
      end else begin
        st_d  = CH_DLY;
        cnt_d = CW'(I_dly) - C_ONE;
      end
    end else begin
      case (st_q)
        CH_DLY: begin
          if (cnt_q == '0) begin
            st_d  = CH_PULSE;
            cnt_d = CW'(I_pw) - C_ONE;
          end else begin
            cnt_d = cnt_q - C_ONE;
          end
        end
        CH_PULSE: begin
          if (cnt_q == '0) begin
            st_d = CH_IDLE;
          end else begin
            cnt_d = cnt_q - C_ONE;
          end
        end
        default: st_d = CH_IDLE;
      endcase
    end
    trig_d = (st_d == CH_PULSE);
  end

  always_ff @(posedge I_clk) begin
    if (I_Rst) begin
      st_q   <= CH_IDLE;
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      trig_q <= trig_d;
    end
  end

  // Looks one cycle ahead so the parent can leave DRAIN without a dead cycle.
  assign O_active = (st_d != CH_IDLE);
  assign O_trig   = trig_q;

endmodule

// File: rtl/trig_seq_gen.sv
// Multi-channel trigger sequencer: start edge launches a burst or a
// continuous train of master ticks fanned out to delayed channels.
module trig_seq_gen
  import trig_seq_gen_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DLY_W = DEF_DLY_W,
  parameter int PW_W  = DEF_PW_W
) (
  input  logic                  I_clk,
  input  logic                  I_Rst,
  input  logic                  I_Trig_in,
  input  logic                  I_Abort,
  input  logic                  I_Mode,
  input  logic [CNT_W-1:0]      I_Trig_Num,
  input  logic [CNT_W-1:0]      I_Trig_Step,
  input  logic [PW_W-1:0]       I_Pulse_W,
  input  logic [N_CH-1:0]       I_Ch_En,
  input  logic [N_CH*DLY_W-1:0] I_Ch_Dly,
  output logic [N_CH-1:0]       O_Trig,
  output logic                  O_Busy,
  output logic                  O_Done,
  output logic [CNT_W-1:0]      O_Trig_Cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);

  seq_st_e               state_q, state_d;
  logic                  trig_in_q, trig_in_d;
  logic [CNT_W-1:0]      per_q, per_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  mode_q, mode_d;
  logic [CNT_W-1:0]      num_q, num_d;
  logic [CNT_W-1:0]      step_q, step_d;
  logic [PW_W-1:0]       pw_q, pw_d;
  logic [N_CH-1:0]       en_q, en_d;
  logic [N_CH*DLY_W-1:0] dly_q, dly_d;

  logic [CNT_W-1:0] step_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic [PW_W-1:0]  pw_eff;
  logic             start;
  logic             tick;
  logic             any_act;
  logic [N_CH-1:0]  trig_w;
  logic [N_CH-1:0]  act_w;

  assign step_eff = (step_q == '0) ? CNT_ONE : step_q;
  assign pw_eff   = (pw_q == '0) ? PW_ONE : pw_q;
  assign cnt_inc  = cnt_q + CNT_ONE;
  assign any_act  = |act_w;
  assign start    = I_Trig_in & ~trig_in_q
                  & (state_q == ST_IDLE)
                  & (I_Mode | (|I_Trig_Num));
  assign tick     = (state_q == ST_RUN)
                  & (per_q == '0) & ~I_Abort;

  always_comb begin
    state_d   = state_q;
    trig_in_d = I_Trig_in;
    per_d     = per_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    mode_d    = mode_q;
    num_d     = num_q;
    step_d    = step_q;
    pw_d      = pw_q;
    en_d      = en_q;
    dly_d     = dly_q;
    if (I_Abort) begin
      state_d = ST_IDLE;
      per_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            per_d   = '0;
            cnt_d   = '0;
            mode_d  = I_Mode;
            num_d   = I_Trig_Num;
            step_d  = I_Trig_Step;
            pw_d    = I_Pulse_W;
            en_d    = I_Ch_En;
            dly_d   = I_Ch_Dly;
          end
        end
        ST_RUN: begin
          per_d = (per_q == step_eff - CNT_ONE)
                ? '0 : per_q + CNT_ONE;
          if (tick) begin
            cnt_d = cnt_inc;
            if (!mode_q && cnt_inc == num_q) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!any_act) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_Rst) begin
      state_q   <= ST_IDLE;
      trig_in_q <= 1'b0;
      per_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
      num_q     <= '0;
      step_q    <= '0;
      pw_q      <= '0;
      en_q      <= '0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      trig_in_q <= trig_in_d;
      per_q     <= per_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      step_q    <= step_d;
      pw_q      <= pw_d;
      en_q      <= en_d;
      dly_q     <= dly_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    trig_ch_dly #(
      .DLY_W(DLY_W),
      .PW_W (PW_W)
    ) u_ch (
      .I_clk   (I_clk),
      .I_Rst   (I_Rst),
      .I_clr   (I_Abort),
      .I_tick  (tick),
      .I_en    (en_q[k]),
      .I_dly   (dly_q[k*DLY_W +: DLY_W]),
      .I_pw    (pw_eff),
      .O_trig  (trig_w[k]),
      .O_active(act_w[k])
    );
  end

  assign O_Trig     = trig_w;
  assign O_Busy     = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign O_Done     = done_q;
  assign O_Trig_Cnt = cnt_q;

endmodule

// File: tb/tb_trig_seq_gen.sv
// Bench for trig_seq_gen: window-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_trig_seq_gen;

  localparam int N_CH  = 17;
  localparam int CNT_W = 32;
  localparam int DLY_W = 16;
  localparam int PW_W  = 8;

  logic                  clk = 1'b0;
  logic                  I_Rst = 1'b1;
  logic                  I_Trig_in = 1'b0;
  logic                  I_Abort = 1'b0;
  logic                  I_Mode = 1'b0;
  logic [CNT_W-1:0]      I_Trig_Num = '0;
  logic [CNT_W-1:0]      I_Trig_Step = '0;
  logic [PW_W-1:0]       I_Pulse_W = '0;
  logic [N_CH-1:0]       I_Ch_En = '0;
  logic [N_CH*DLY_W-1:0] I_Ch_Dly = '0;
  logic [N_CH-1:0]       O_Trig;
  logic                  O_Busy;
  logic                  O_Done;
  logic [CNT_W-1:0]      O_Trig_Cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trig_seq_gen #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DLY_W(DLY_W), .PW_W(PW_W)
  ) dut (
    .I_clk      (clk),
    .I_Rst      (I_Rst),
    .I_Trig_in  (I_Trig_in),
    .I_Abort    (I_Abort),
    .I_Mode     (I_Mode),
    .I_Trig_Num (I_Trig_Num),
    .I_Trig_Step(I_Trig_Step),
    .I_Pulse_W  (I_Pulse_W),
    .I_Ch_En    (I_Ch_En),
    .I_Ch_Dly   (I_Ch_Dly),
    .O_Trig     (O_Trig),
    .O_Busy     (O_Busy),
    .O_Done     (O_Done),
    .O_Trig_Cnt (O_Trig_Cnt)
  );

  // Reference model: each channel is a [start,end] cycle window of high output.
  longint          cyc = 0;
  int              m_st = 0;
  bit              m_prev = 0;
  bit              c_mode;
  longint          c_num, c_se, c_pw, t0;
  bit [N_CH-1:0]   c_en;
  longint          c_dly[N_CH];
  longint          ws[N_CH];
  longint          we[N_CH];
  longint unsigned m_cnt = 0;
  logic [N_CH-1:0] exp_trig = '0;
  bit              exp_busy = 0;
  bit              exp_done = 0;
  bit              model_ok = 0;

  task automatic model_step();
    longint c;
    bit     edg;
    bit     quiet;
    c = cyc;
    cyc++;
    exp_done = 0;
    if (I_Rst) begin
      m_st = 0;
      m_prev = 0;
      m_cnt = 0;
      for (int k = 0; k < N_CH; k++) begin
        ws[k] = 1; we[k] = 0;
      end
    end else begin
      edg = I_Trig_in && !m_prev;
      m_prev = I_Trig_in;
      if (I_Abort) begin
        m_st = 0;
        for (int k = 0; k < N_CH; k++) begin
          ws[k] = 1; we[k] = 0;
        end
      end else if (m_st == 0) begin
        if (edg && (I_Mode || I_Trig_Num != 0)) begin
          c_mode = I_Mode;
          c_num  = longint'(I_Trig_Num);
          c_se   = (I_Trig_Step == 0) ? 1 : longint'(I_Trig_Step);
          c_pw   = (I_Pulse_W == 0) ? 1 : longint'(I_Pulse_W);
          c_en   = I_Ch_En;
          for (int k = 0; k < N_CH; k++)
            c_dly[k] = longint'(I_Ch_Dly[k*DLY_W +: DLY_W]);
          t0 = c;
          m_cnt = 0;
          m_st = 1;
        end
      end else if (m_st == 1) begin
        if ((c - t0 - 1) % c_se == 0) begin
          m_cnt = (m_cnt + 1) & 64'hFFFF_FFFF;
          for (int k = 0; k < N_CH; k++) begin
            if (c_en[k]) begin
              ws[k] = c + 1 + c_dly[k];
              we[k] = c + c_dly[k] + c_pw;
            end
          end
          if (!c_mode && longint'(m_cnt) == c_num) m_st = 2;
        end
      end else begin
        quiet = 1;
        for (int k = 0; k < N_CH; k++)
          if (we[k] > c) quiet = 0;
        if (quiet) begin
          m_st = 0;
          exp_done = 1;
        end
      end
    end
    exp_busy = (m_st != 0);
    for (int k = 0; k < N_CH; k++)
      exp_trig[k] = (ws[k] <= c + 1) && (c + 1 <= we[k]);
    model_ok = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      checks++;
      if (O_Trig !== exp_trig || O_Busy !== exp_busy ||
          O_Done !== exp_done || O_Trig_Cnt !== m_cnt[31:0]) begin
        errors++;
        $display("FAIL model cyc %0d: trig=%h exp %h busy=%b exp %b done=%b exp %b cnt=%0d exp %0d",
                 cyc, O_Trig, exp_trig, O_Busy, exp_busy,
                 O_Done, exp_done, O_Trig_Cnt, m_cnt[31:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  longint ta = 0;

  task automatic cfg(input bit md, input int num, input int step,
                     input int pw, input logic [N_CH-1:0] en,
                     input int d0, input int d1, input int d2);
    I_Mode = md;
    I_Trig_Num = CNT_W'(num);
    I_Trig_Step = CNT_W'(step);
    I_Pulse_W = PW_W'(pw);
    I_Ch_En = en;
    I_Ch_Dly = '0;
    I_Ch_Dly[0*DLY_W +: DLY_W] = DLY_W'(d0);
    I_Ch_Dly[1*DLY_W +: DLY_W] = DLY_W'(d1);
    I_Ch_Dly[2*DLY_W +: DLY_W] = DLY_W'(d2);
  endtask

  // Edge is sampled at the next posedge; that cycle is t, after it is t+1.
  task automatic start_edge();
    I_Trig_in = 1'b1;
    @(posedge clk);
    #1;
    I_Trig_in = 1'b0;
    ta = cyc;
  endtask

  // Move to the negedge of cycle t+k.
  task automatic at(input int k);
    while (cyc < ta + k - 1) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N_CH-1:0] all_en;
    all_en = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_trig", 64'(O_Trig), 0);
    chk("reset_busy", 64'(O_Busy), 0);
    chk("reset_done", 64'(O_Done), 0);
    chk("reset_cnt", 64'(O_Trig_Cnt), 0);
    I_Rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic burst
    cfg(0, 3, 10, 2, all_en, 0, 4, 0);
    start_edge();
    at(2);  chk("b_ch0_t2", 64'(O_Trig[0]), 1);
    chk("b_ch1_t2", 64'(O_Trig[1]), 0);
    at(6);  chk("b_ch1_t6", 64'(O_Trig[1]), 1);
    at(8);  chk("b_ch1_t8", 64'(O_Trig[1]), 0);
    at(12); chk("b_ch0_t12", 64'(O_Trig[0]), 1);
    at(27); chk("b_busy_t27", 64'(O_Busy), 1);
    chk("b_done_t27", 64'(O_Done), 0);
    at(28); chk("b_done_t28", 64'(O_Done), 1);
    chk("b_busy_t28", 64'(O_Busy), 0);
    chk("b_cnt_t28", 64'(O_Trig_Cnt), 3);
    at(29); chk("b_done_t29", 64'(O_Done), 0);

    // Burst with zero count is ignored
    cfg(0, 0, 4, 2, all_en, 0, 0, 0);
    start_edge();
    at(2); chk("z_busy", 64'(O_Busy), 0);
    at(4); chk("z_trig", 64'(O_Trig), 0);
    chk("z_done", 64'(O_Done), 0);
    chk("z_cnt_hold", 64'(O_Trig_Cnt), 3);

    // Continuous with mid-run edge, config change and abort
    cfg(1, 0, 5, 1, all_en, 1, 2, 0);
    start_edge();
    at(30); I_Trig_Step = CNT_W'(7);
    at(50); I_Trig_in = 1'b1;
    at(51); I_Trig_in = 1'b0;
    at(100); I_Abort = 1'b1;
    at(101); I_Abort = 1'b0;
    chk("c_trig", 64'(O_Trig), 0);
    chk("c_busy", 64'(O_Busy), 0);
    chk("c_done", 64'(O_Done), 0);
    chk("c_cnt", 64'(O_Trig_Cnt), 20);
    at(102); chk("c_done2", 64'(O_Done), 0);

    // Zero step and width are treated as one
    cfg(0, 4, 0, 0, all_en, 0, 0, 0);
    start_edge();
    at(2); chk("s_ch0_t2", 64'(O_Trig[0]), 1);
    at(5); chk("s_ch0_t5", 64'(O_Trig[0]), 1);
    chk("s_cnt_t5", 64'(O_Trig_Cnt), 4);
    at(6); chk("s_ch0_t6", 64'(O_Trig[0]), 0);
    chk("s_done_t6", 64'(O_Done), 1);

    // Retrigger truncates the pending delay
    cfg(0, 2, 3, 1, all_en, 0, 0, 5);
    start_edge();
    at(7);  chk("r_ch2_t7", 64'(O_Trig[2]), 0);
    at(10); chk("r_ch2_t10", 64'(O_Trig[2]), 1);
    at(11); chk("r_ch2_t11", 64'(O_Trig[2]), 0);
    chk("r_done_t11", 64'(O_Done), 1);

    // Reset mid-pulse, then clean restart
    cfg(0, 5, 10, 4, all_en, 0, 0, 0);
    start_edge();
    at(4); chk("x_ch0_t4", 64'(O_Trig[0]), 1);
    I_Rst = 1'b1;
    at(5); I_Rst = 1'b0;
    chk("x_trig", 64'(O_Trig), 0);
    chk("x_busy", 64'(O_Busy), 0);
    chk("x_cnt", 64'(O_Trig_Cnt), 0);
    at(8);
    start_edge();
    at(2); chk("x_busy_re", 64'(O_Busy), 1);
    chk("x_ch0_re", 64'(O_Trig[0]), 1);
    at(60); chk("x_cnt_re", 64'(O_Trig_Cnt), 5);

    // Random traffic, including config changes during runs
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      I_Trig_in = ($urandom_range(0, 3) == 0);
      I_Abort = ($urandom_range(0, 99) == 0);
      I_Rst = ($urandom_range(0, 499) == 0);
      I_Mode = ($urandom_range(0, 7) == 0);
      I_Trig_Num = CNT_W'($urandom_range(0, 5));
      I_Trig_Step = CNT_W'($urandom_range(0, 12));
      I_Pulse_W = PW_W'($urandom_range(0, 4));
      I_Ch_En = N_CH'($urandom);
      for (int k = 0; k < N_CH; k++)
        I_Ch_Dly[k*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 8));
    end
    @(posedge clk);
    #1;
    I_Trig_in = 1'b0;
    I_Rst = 1'b0;
    I_Abort = 1'b1;
    @(posedge clk);
    #1;
    I_Abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_busy", 64'(O_Busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
